// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, FSM state type and 32-bit saturation helper for the neuron MAC feed.
package nn_pkg;
  localparam int ACT_W  = 11;
  localparam int WT_W   = 16;
  localparam int OUT_W  = 32;
  localparam int ACC_W  = 40;
  localparam int PROD_W = WT_W + ACT_W + 1;
  typedef enum logic {IDLE, ACC} state_e;
  function automatic logic signed [OUT_W-1:0] sat32(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-OUT_W:0] hi;
    hi = a[ACC_W-1:OUT_W-1];
    return (&hi | ~|hi) ? a[OUT_W-1:0] : {a[ACC_W-1], {(OUT_W-1){~a[ACC_W-1]}}};
  endfunction
endpackage

// File: rtl/mac_stage_mult.sv
// mac_stage_mult: registered signed weight x unsigned activation product, shaped for a single DSP slice.
module mac_stage_mult
  import nn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic        [ACT_W-1:0]  act_i,
  input  logic signed [WT_W-1:0]   wt_i,
  output logic signed [PROD_W-1:0] prod_o
);
  logic signed [PROD_W-1:0] wt_x, act_x, prod_q;
  assign wt_x   = PROD_W'(wt_i);
  assign act_x  = PROD_W'({1'b0, act_i});
  assign prod_o = prod_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else if (en_i) prod_q <= wt_x * act_x;
  end
endmodule

// File: rtl/neuron_mac_feed.sv
// neuron_mac_feed: bias + dot-product accumulator feeding the sigmoid input (dv_out/mac_out).
// Define NEURON_MAC_SAT_EN to saturate mac_out to 32 bits; otherwise it wraps.
module neuron_mac_feed
  import nn_pkg::*;
#(
  parameter int MAX_LEN = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dv_in,
  input  logic                    last_in,
  input  logic        [ACT_W-1:0] act_in,
  input  logic signed [WT_W-1:0]  wt_in,
  input  logic signed [OUT_W-1:0] bias_in,
  output logic                    busy,
  output logic                    dv_out,
  output logic        [OUT_W-1:0] mac_out,
  output logic                    len_err
);
  localparam int CW = $clog2(MAX_LEN);
  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     forced, close;
  logic                     s1_valid_q, s1_first_q, s1_last_q;
  logic signed [OUT_W-1:0]  bias_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     done_q, res_v_q, dv_out_q, len_err_q;
  logic        [OUT_W-1:0]  res_d, res_q, mac_out_q;

  assign forced = (state_q == ACC) & dv_in & ~last_in & (cnt_q == CW'(MAX_LEN - 1));
  assign close  = dv_in & (last_in | forced);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (dv_in) begin
      state_d = close ? IDLE : ACC;
      cnt_d   = close ? '0 : (state_q == IDLE ? CW'(1) : cnt_q + CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mac_stage_mult u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (dv_in),
    .act_i  (act_in),
    .wt_i   (wt_in),
    .prod_o (prod)
  );

`ifdef NEURON_MAC_SAT_EN
  assign res_d = sat32(acc_q);
`else
  assign res_d = OUT_W'(acc_q);
`endif

  // acc is captured into res one cycle after it completes so a back-to-back vector can reload it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      bias_q     <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
      res_v_q    <= 1'b0;
      res_q      <= '0;
      dv_out_q   <= 1'b0;
      mac_out_q  <= '0;
      len_err_q  <= 1'b0;
    end else begin
      s1_valid_q <= dv_in;
      s1_first_q <= state_q == IDLE;
      s1_last_q  <= close;
      if (dv_in && state_q == IDLE) bias_q <= bias_in;
      if (s1_valid_q) acc_q <= (s1_first_q ? ACC_W'(bias_q) : acc_q) + ACC_W'(prod);
      done_q     <= s1_valid_q & s1_last_q;
      res_v_q    <= done_q;
      if (done_q) res_q <= res_d;
      dv_out_q   <= res_v_q;
      if (res_v_q) mac_out_q <= res_q;
      len_err_q  <= len_err_q | forced;
    end
  end

  assign busy    = (state_q == ACC) | s1_valid_q | done_q | res_v_q;
  assign dv_out  = dv_out_q;
  assign mac_out = mac_out_q;
  assign len_err = len_err_q;
endmodule

// File: tb/tb_neuron_mac_feed.sv
// tb_neuron_mac_feed: directed and random vectors checked against an arithmetic dot-product model.
module tb_neuron_mac_feed;
  localparam int MAX_LEN = 256;
  logic        clk = 1'b0, rst_n = 1'b0, dv_in = 1'b0, last_in = 1'b0;
  logic [10:0] act_in = '0;
  logic [15:0] wt_in = '0;
  logic [31:0] bias_in = '0;
  logic        busy, dv_out, len_err;
  logic [31:0] mac_out;
  typedef struct {longint v; int c;} exp_t;
  exp_t   q[$];
  int     cyc = 0, n_vec = 0, n_err = 0, m_cnt = 0;
  longint m_sum = 0;
  bit     m_open = 0, exp_len_err = 0;

  neuron_mac_feed #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .dv_in(dv_in), .last_in(last_in), .act_in(act_in),
    .wt_in(wt_in), .bias_in(bias_in), .busy(busy), .dv_out(dv_out), .mac_out(mac_out),
    .len_err(len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint to_out(input longint s);
`ifdef NEURON_MAC_SAT_EN
    return s > 64'sd2147483647 ? 64'sd2147483647 : (s < -64'sd2147483648 ? -64'sd2147483648 : s);
`else
    return longint'(int'(s));
`endif
  endfunction

  task automatic beat(input int act, input int wt, input int bias, input bit last);
    @(negedge clk);
    dv_in = 1'b1; last_in = last; act_in = 11'(act); wt_in = 16'(wt); bias_in = 32'(bias);
    if (!m_open) begin m_sum = longint'(bias); m_cnt = 0; end
    m_sum += longint'(wt) * longint'(act);
    m_cnt++;
    m_open = 1;
    if (last || m_cnt == MAX_LEN) begin
      if (!last) exp_len_err = 1;
      q.push_back('{to_out(m_sum), cyc + 4});
      m_open = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dv_in = 1'b0; last_in = 1'b0; act_in = 11'($urandom); wt_in = 16'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (dv_out) begin
      if (q.size() == 0) check("dv_extra", dv_out, 0);
      else begin
        check("mac_out", longint'(signed'(mac_out)), q[0].v);
        check("dv_lat", cyc, q[0].c);
        void'(q.pop_front());
      end
    end else if (q.size() != 0 && q[0].c <= cyc) begin
      check("dv_missing", dv_out, 1);
      void'(q.pop_front());
    end
  end

  initial begin
    idle(3);
    check("rst_busy", busy, 0);
    check("rst_mac", mac_out, 0);
    check("rst_len_err", len_err, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat(2047, 100, 5, i == 2);
      if (i == 1) check("busy_open", busy, 1);
    end
    idle(6);
    beat(1024, -2, 0, 1);
    idle(6);
    beat(10, 3, 1, 0); beat(10, 3, 77, 1); beat(5, -1, 0, 1);
    idle(6);
    for (int i = 0; i < 40; i++) beat(2047, 32767, 0, i == 39);
    idle(6);
    check("busy_idle", busy, 0);
    for (int i = 0; i < 30; i++) begin
      int len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        beat($urandom_range(2047), int'($urandom_range(65535)) - 32768, int'($urandom), b == len - 1);
        if ($urandom_range(3) == 0) idle($urandom_range(1, 2));
      end
      if ($urandom_range(1) == 0) idle($urandom_range(1, 3));
    end
    idle(6);
    check("no_len_err", len_err, exp_len_err);
    for (int i = 0; i < MAX_LEN + 1; i++) beat($urandom_range(2047), int'($urandom_range(65535)) - 32768, 3, 0);
    beat(7, 9, 11, 1);
    idle(6);
    check("len_err", len_err, exp_len_err);
    beat(100, 100, 0, 0); beat(100, 100, 0, 0);
    @(negedge clk);
    rst_n = 1'b0; dv_in = 1'b0; last_in = 1'b0;
    q.delete(); m_open = 0; exp_len_err = 0;
    #1;
    check("mid_rst_mac", mac_out, 0);
    check("mid_rst_len_err", len_err, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    beat(1, 1, 0, 1);
    idle(8);
    check("pending", q.size(), 0);
    check("end_len_err", len_err, exp_len_err);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
